regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Sole driver of the register file write port (RegWrite/WAddr/WData). After reset it sweeps all 32
//  registers with their power-on values, so the design does not rely on simulation-only initial blocks.
//  After the sweep it arbitrates the single write port between the ALU and memory-load write-back
//  sources, using round-robin arbitration and a valid/ready handshake. Writes to protected registers
//  ($0, $26, $27) are accepted and dropped.
// PARAMETERS
//  DATA_WIDTH  32    write data width
//  ADDR_WIDTH  5     register index width (32 registers)
//  INIT_BIAS   100   init value added to index for $2..$25
//  STACK_TOP   1020  init value of $29
// PORTS
//  Clk       in   1    clock, all state updates on posedge
//  Rst_n     in   1    asynchronous active-low reset
//  Reinit    in   1    one-cycle pulse in ARB: restart the init sweep
//  AluValid  in   1    ALU write-back request
//  AluReady  out  1    ALU request accepted this cycle (combinational)
//  AluAddr   in   5    ALU destination register
//  AluData   in   32   ALU result (signed)
//  MemValid  in   1    load write-back request
//  MemReady  out  1    load request accepted this cycle (combinational)
//  MemAddr   in   5    load destination register
//  MemData   in   32   load data (signed)
//  RegWrite  out  1    register file write enable (registered)
//  WAddr     out  5    register file write address (registered)
//  WData     out  32   register file write data (registered)
//  InitDone  out  1    high while in ARB
//  Dropped   out  1    one-cycle pulse: an accepted request targeted $0/$26/$27
// BEHAVIOUR
//  - Reset (Rst_n=0, async): state=INIT, idx=0, prio=ALU, RegWrite=0, WAddr=0, WData=0,
//    InitDone=0, Dropped=0. Reset asserted mid-sweep or mid-transfer discards everything.
//  - INIT state, one entry per posedge, idx 0..31:
//      - Outputs load WAddr=idx and WData=init(idx).
//      - RegWrite=0 for idx in {0,26,27}; RegWrite=1 otherwise.
//      - init(idx) = idx+INIT_BIAS for 2..25; STACK_TOP for 29; 0 for all others.
//      - The edge that loads idx=31 also sets state=ARB and InitDone=1.
//      - The sweep takes exactly 32 edges. AluReady=MemReady=0 throughout.
//  - ARB state:
//      AluReady = !Reinit & (!MemValid | prio==ALU)
//      MemReady = !Reinit & (!AluValid | prio==MEM)
//    Ready never depends on the requester's own Valid.
//  - Accept (Valid & Ready at posedge k):
//      - Outputs are registered: WAddr and WData take the winner's Addr/Data; RegWrite=1.
//      - The register file commits at posedge k+1. Latency is one cycle.
//      - prio is set to the other source only when both were valid at k. A sole requester
//        leaves prio unchanged.
//  - Protected address accepted: RegWrite=0, Dropped=1 for one cycle. Arbitration and prio
//    update proceed as for a normal accept.
//  - No accept at posedge: RegWrite=0, Dropped=0; WAddr/WData hold their previous values.
//  - Throughput: one accept per cycle. Back-to-back writes need no bubble.
//  - Reinit=1 in ARB:
//      - No accept that cycle.
//      - Next edge: state=INIT, idx=0, InitDone=0, RegWrite=0.
//      - The write already in flight from the previous edge still commits.
//    Reinit is ignored in INIT.
//  - Requesters hold Valid/Addr/Data stable until accepted. An unaccepted request is never lost.
// TESTING
//  1. Release Rst_n, run 32 cycles:
//     - Write trace: $2=102 ... $25=125, $29=1020; zero for the rest.
//     - No RegWrite for $0/$26/$27.
//     - InitDone rises after edge 32.
//  2. ARB, AluValid=1 only, AluAddr=8, AluData=-5: AluReady=1; next cycle RegWrite=1, WAddr=8,
//     WData=-5; prio unchanged.
//  3. Both valid continuously, Alu->$3=7, Mem->$4=9: grants alternate ALU, MEM, ALU, MEM
//     starting from ALU; one write per cycle.
//  4. MemValid with MemAddr=26: MemReady=1; next cycle RegWrite=0 and Dropped=1; MemAddr=0
//     gives the same result.
//  5. Assert Rst_n=0 at idx=10 for 1 cycle, release: outputs clear immediately and the sweep
//     restarts at idx 0 (32 more edges).
//  6. Pulse Reinit together with AluValid: AluReady=0; full sweep repeats; the ALU request is
//     accepted on the first ARB cycle.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: sole driver of the register file write port.
// After reset it sweeps all registers with their power-on values, then arbitrates
// the write port between ALU and load write-back using round-robin and valid/ready.
// Writes to $0, $26 and $27 are accepted but dropped (Dropped pulses instead of RegWrite).
// Ports:
//   Clk, Rst_n              clock, async active-low reset
//   Reinit                  restart the init sweep (ignored during the sweep)
//   AluValid/Ready/Addr/Data  ALU write-back request (Ready is combinational)
//   MemValid/Ready/Addr/Data  load write-back request (Ready is combinational)
//   RegWrite/WAddr/WData    registered register file write port
//   InitDone                high while arbitrating
//   Dropped                 one-cycle pulse for an accepted protected-register write
module regfile_wb_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned INIT_BIAS  = 100,
    parameter int unsigned STACK_TOP  = 1020
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Reinit,
    input  logic                  AluValid,
    output logic                  AluReady,
    input  logic [ADDR_WIDTH-1:0] AluAddr,
    input  logic [DATA_WIDTH-1:0] AluData,
    input  logic                  MemValid,
    output logic                  MemReady,
    input  logic [ADDR_WIDTH-1:0] MemAddr,
    input  logic [DATA_WIDTH-1:0] MemData,
    output logic                  RegWrite,
    output logic [ADDR_WIDTH-1:0] WAddr,
    output logic [DATA_WIDTH-1:0] WData,
    output logic                  InitDone,
    output logic                  Dropped
);

    typedef enum logic {ST_INIT = 1'b0, ST_ARB = 1'b1} state_e;
    typedef enum logic {PRIO_ALU = 1'b0, PRIO_MEM = 1'b1} prio_e;

    state_e                  state_q, state_d;
    prio_e                   prio_q, prio_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic                    regwrite_d, dropped_d, initdone_d;
    logic [ADDR_WIDTH-1:0]   waddr_d;
    logic [DATA_WIDTH-1:0]   wdata_d;
    logic                    alu_acc, mem_acc;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [DATA_WIDTH-1:0]   win_data;

    // Registers that must never be written: $0, $26, $27.
    function automatic logic is_protected(input logic [ADDR_WIDTH-1:0] a);
        return (a == ADDR_WIDTH'(0)) || (a == ADDR_WIDTH'(26)) || (a == ADDR_WIDTH'(27));
    endfunction

    // Power-on value of register a.
    function automatic logic [DATA_WIDTH-1:0] init_value(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        if (a >= ADDR_WIDTH'(2) && a <= ADDR_WIDTH'(25))
            v = DATA_WIDTH'(a) + DATA_WIDTH'(INIT_BIAS);
        else if (a == ADDR_WIDTH'(29))
            v = DATA_WIDTH'(STACK_TOP);
        return v;
    endfunction

    // Ready never looks at the requester's own Valid; only the competitor's Valid and prio.
    always_comb begin
        AluReady = (state_q == ST_ARB) && !Reinit && (!MemValid || prio_q == PRIO_ALU);
        MemReady = (state_q == ST_ARB) && !Reinit && (!AluValid || prio_q == PRIO_MEM);
        alu_acc  = AluValid && AluReady;
        mem_acc  = MemValid && MemReady;
        win_addr = alu_acc ? AluAddr : MemAddr;
        win_data = alu_acc ? AluData : MemData;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        idx_d      = idx_q;
        regwrite_d = 1'b0;
        dropped_d  = 1'b0;
        initdone_d = InitDone;
        waddr_d    = WAddr;
        wdata_d    = WData;
        case (state_q)
            ST_INIT: begin
                waddr_d    = idx_q;
                wdata_d    = init_value(idx_q);
                regwrite_d = !is_protected(idx_q);
                idx_d      = idx_q + ADDR_WIDTH'(1);
                if (idx_q == '1) begin
                    state_d    = ST_ARB;
                    initdone_d = 1'b1;
                end
            end
            ST_ARB: begin
                if (Reinit) begin
                    state_d    = ST_INIT;
                    idx_d      = '0;
                    initdone_d = 1'b0;
                end else if (alu_acc || mem_acc) begin
                    waddr_d    = win_addr;
                    wdata_d    = win_data;
                    regwrite_d = !is_protected(win_addr);
                    dropped_d  = is_protected(win_addr);
                    // Round-robin only advances when there was real contention.
                    if (AluValid && MemValid)
                        prio_d = (prio_q == PRIO_ALU) ? PRIO_MEM : PRIO_ALU;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // State and output registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= ST_INIT;
            prio_q   <= PRIO_ALU;
            idx_q    <= '0;
            RegWrite <= 1'b0;
            WAddr    <= '0;
            WData    <= '0;
            InitDone <= 1'b0;
            Dropped  <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            idx_q    <= idx_d;
            RegWrite <= regwrite_d;
            WAddr    <= waddr_d;
            WData    <= wdata_d;
            InitDone <= initdone_d;
            Dropped  <= dropped_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter; outputs sampled on the falling edge.
module tb_regfile_wb_arbiter;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Reinit;
    logic        AluValid, MemValid;
    logic        AluReady, MemReady;
    logic [4:0]  AluAddr, MemAddr;
    logic [31:0] AluData, MemData;
    logic        RegWrite;
    logic [4:0]  WAddr;
    logic [31:0] WData;
    logic        InitDone, Dropped;

    int checks   = 0;
    int failures = 0;

    regfile_wb_arbiter dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Reinit   (Reinit),
        .AluValid (AluValid),
        .AluReady (AluReady),
        .AluAddr  (AluAddr),
        .AluData  (AluData),
        .MemValid (MemValid),
        .MemReady (MemReady),
        .MemAddr  (MemAddr),
        .MemData  (MemData),
        .RegWrite (RegWrite),
        .WAddr    (WAddr),
        .WData    (WData),
        .InitDone (InitDone),
        .Dropped  (Dropped)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Hand-written power-on table: $2..$25 = idx+100, $29 = 1020, rest 0.
    function automatic logic [31:0] exp_init(input int e);
        if (e >= 2 && e <= 25) return 32'(e + 100);
        if (e == 29)           return 32'd1020;
        return 32'd0;
    endfunction

    // Called at a falling edge with the design in INIT at idx 0; checks all 32 sweep entries.
    task automatic run_sweep(input string name);
        for (int e = 0; e < 32; e++) begin
            check($sformatf("%s_aluready%0d", name, e), {31'd0, AluReady}, 32'd0);
            check($sformatf("%s_memready%0d", name, e), {31'd0, MemReady}, 32'd0);
            @(posedge Clk);
            @(negedge Clk);
            check($sformatf("%s_waddr%0d", name, e), {27'd0, WAddr}, 32'(e));
            check($sformatf("%s_wdata%0d", name, e), WData, exp_init(e));
            check($sformatf("%s_regwrite%0d", name, e), {31'd0, RegWrite},
                  (e == 0 || e == 26 || e == 27) ? 32'd0 : 32'd1);
            check($sformatf("%s_initdone%0d", name, e), {31'd0, InitDone},
                  (e == 31) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        Rst_n = 1'b0; Reinit = 1'b0;
        AluValid = 1'b0; AluAddr = '0; AluData = '0;
        MemValid = 1'b0; MemAddr = '0; MemData = '0;
        repeat (2) @(negedge Clk);
        check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        check("rst_waddr", {27'd0, WAddr}, 32'd0);
        check("rst_wdata", WData, 32'd0);
        check("rst_initdone", {31'd0, InitDone}, 32'd0);
        check("rst_dropped", {31'd0, Dropped}, 32'd0);

        // 1. Init sweep
        Rst_n = 1'b1;
        run_sweep("sweep1");

        // 2. Sole ALU request
        AluValid = 1'b1; AluAddr = 5'd8; AluData = -32'sd5;
        #1;
        check("t2_aluready", {31'd0, AluReady}, 32'd1);
        check("t2_memready", {31'd0, MemReady}, 32'd0);
        @(posedge Clk); @(negedge Clk);
        AluValid = 1'b0;
        check("t2_regwrite", {31'd0, RegWrite}, 32'd1);
        check("t2_waddr", {27'd0, WAddr}, 32'd8);
        check("t2_wdata", WData, 32'hFFFF_FFFB);
        check("t2_dropped", {31'd0, Dropped}, 32'd0);

        // 3. Contention: prio still ALU, so grants go ALU, MEM, ALU, MEM
        AluValid = 1'b1; AluAddr = 5'd3; AluData = 32'd7;
        MemValid = 1'b1; MemAddr = 5'd4; MemData = 32'd9;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("t3_aluready%0d", i), {31'd0, AluReady}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("t3_memready%0d", i), {31'd0, MemReady}, (i % 2 == 0) ? 32'd0 : 32'd1);
            @(posedge Clk); @(negedge Clk);
            check($sformatf("t3_regwrite%0d", i), {31'd0, RegWrite}, 32'd1);
            check($sformatf("t3_waddr%0d", i), {27'd0, WAddr}, (i % 2 == 0) ? 32'd3 : 32'd4);
            check($sformatf("t3_wdata%0d", i), WData, (i % 2 == 0) ? 32'd7 : 32'd9);
        end
        AluValid = 1'b0; MemValid = 1'b0;
        @(posedge Clk); @(negedge Clk);
        check("t3_idle_regwrite", {31'd0, RegWrite}, 32'd0);
        check("t3_idle_waddr_hold", {27'd0, WAddr}, 32'd4);
        check("t3_idle_wdata_hold", WData, 32'd9);

        // 4. Protected destinations from the load path
        MemValid = 1'b1; MemAddr = 5'd26; MemData = 32'd55;
        #1;
        check("t4_memready26", {31'd0, MemReady}, 32'd1);
        @(posedge Clk); @(negedge Clk);
        check("t4_regwrite26", {31'd0, RegWrite}, 32'd0);
        check("t4_dropped26", {31'd0, Dropped}, 32'd1);
        MemAddr = 5'd0;
        #1;
        check("t4_memready0", {31'd0, MemReady}, 32'd1);
        @(posedge Clk); @(negedge Clk);
        check("t4_regwrite0", {31'd0, RegWrite}, 32'd0);
        check("t4_dropped0", {31'd0, Dropped}, 32'd1);
        MemValid = 1'b0;
        @(posedge Clk); @(negedge Clk);
        check("t4_dropped_clear", {31'd0, Dropped}, 32'd0);

        // 5. Reset mid-sweep
        Rst_n = 1'b0;
        #1;
        check("t5_rst_initdone", {31'd0, InitDone}, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (10) @(posedge Clk);
        @(negedge Clk);
        check("t5_mid_waddr", {27'd0, WAddr}, 32'd9);
        Rst_n = 1'b0;
        #1;
        check("t5_clr_waddr", {27'd0, WAddr}, 32'd0);
        check("t5_clr_wdata", WData, 32'd0);
        check("t5_clr_regwrite", {31'd0, RegWrite}, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        run_sweep("sweep2");

        // 6. Reinit with a pending ALU request
        Reinit = 1'b1; AluValid = 1'b1; AluAddr = 5'd5; AluData = 32'd77;
        #1;
        check("t6_aluready_reinit", {31'd0, AluReady}, 32'd0);
        @(posedge Clk); @(negedge Clk);
        Reinit = 1'b0;
        check("t6_initdone_low", {31'd0, InitDone}, 32'd0);
        check("t6_regwrite_low", {31'd0, RegWrite}, 32'd0);
        run_sweep("sweep3");
        #1;
        check("t6_aluready_arb", {31'd0, AluReady}, 32'd1);
        @(posedge Clk); @(negedge Clk);
        AluValid = 1'b0;
        check("t6_regwrite", {31'd0, RegWrite}, 32'd1);
        check("t6_waddr", {27'd0, WAddr}, 32'd5);
        check("t6_wdata", WData, 32'd77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
